pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central sequencing unit for the five-stage pipeline.
- Generates enable/flush for the fetch, decode, execute and memory pipeline latches, plus the PC enable.
- Arbitrates the single memory port between instruction fetch and data access, inserts load-use bubbles, squashes wrong-path instructions on redirect, and drains the pipe on halt.
- Keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
mem_dREN  in  1  MEM-stage instruction is a load
mem_dWEN  in  1  MEM-stage instruction is a store
mem_pcsrc  in  1  taken branch/jump resolved in MEM; PC redirect
mem_halt  in  1  MEM-stage instruction is halt
ex_dREN  in  1  EX-stage instruction is a load
ex_wsel  in  5  destination register of EX-stage instruction
id_rs  in  5  rs field of ID-stage instruction
id_rt  in  5  rt field of ID-stage instruction
id_uses_rt  in  1  ID-stage instruction reads rt
pc_en  out  1  PC update enable
fl_en, fl_flush  out  1,1  fetch latch enable/flush
dl_en, dl_flush  out  1,1  decode latch enable/flush
el_en, el_flush  out  1,1  execute latch enable/flush
ml_en, ml_flush  out  1,1  memory latch enable/flush
halt  out  1  pipeline halted, sticky
stall_cnt  out  CNT_W  cycles spent stalled
flush_cnt  out  CNT_W  redirects taken

Behaviour:
- FSM states: RUN, DWAIT, HALTED. On RST: state=RUN, counters=0.
- While RST is high, all outputs are 0. This also applies to RST asserted mid-operation.
- Outputs are combinational from state and inputs. Whenever a latch's flush=1, its en=0.
- Definitions:
  - memop = mem_dREN | mem_dWEN.
  - lu = ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)).
- RUN priority, highest first:
  1. mem_halt: ml_en=1; fl_flush=dl_flush=el_flush=1; pc_en=0. Next state HALTED.
  2. memop & !dhit: all en=0, all flush=0 (freeze). Next state DWAIT. stall_cnt++.
  3. memop & dhit: dl_en=el_en=ml_en=1; fl_flush=1; pc_en=0. The memory port was used by data, so this injects a fetch bubble. Same-cycle mem_pcsrc is handled as rule 4 in addition: redirect overrides, pc_en=1, dl_flush=el_flush=1. Stays RUN.
  4. mem_pcsrc (no memop): pc_en=1; fl_flush=dl_flush=el_flush=1; ml_en=1. flush_cnt++.
  5. lu: pc_en=0, fl_en=0, dl_flush=1, el_en=1, ml_en=1. stall_cnt++.
  6. !ihit: pc_en=0, fl_flush=1; dl_en=el_en=ml_en=1. stall_cnt++.
  7. Otherwise: all en=1, all flush=0.
- DWAIT:
  - !dhit: freeze as in rule 2; stall_cnt++.
  - dhit: outputs as rule 3, including the redirect override if mem_pcsrc=1 (flush_cnt++). Next state RUN.
  - mem_halt cannot be present in DWAIT, because halt is never a memop.
  - ihit is ignored in DWAIT.
- HALTED: all en=0, flush=0, halt=1. Remains HALTED until RST; all inputs ignored.
- halt=1 only in HALTED, i.e. starting the cycle after mem_halt was seen.
- Counters saturate at 2^CNT_W-1. They do not wrap.
- The x0 destination never causes a load-use stall.

Test Plan:
- Reset: hold RST=1 with random inputs → all outputs 0. Release with ihit=1, no hazards → pc_en=fl_en=dl_en=el_en=ml_en=1, halt=0.
- Load-use: ex_dREN=1, ex_wsel=5, id_rs=5, ihit=1 → pc_en=0, fl_en=0, dl_flush=1, el_en=ml_en=1, stall_cnt 0→1. Repeat with ex_wsel=0 → no stall.
- Data wait: mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 → 3 frozen cycles (all en/flush 0) and stall_cnt=3. On the dhit cycle fl_flush=1, dl_en=el_en=ml_en=1, pc_en=0. FSM back in RUN.
- Redirect: mem_pcsrc=1, ihit=1 → pc_en=1, fl_flush=dl_flush=el_flush=1, ml_en=1, flush_cnt=1. Redirect with simultaneous lu → redirect wins, no stall_cnt increment.
- Halt: mem_halt=1 → ml_en=1, upstream flushed. Next cycle halt=1, all en 0. Stays halted under any input until RST pulse, then RUN.
- Saturation: CNT_W=2, 5 consecutive !ihit cycles → stall_cnt=3.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundle of hazard/status inputs and latch-control outputs exchanged between
// the five-stage pipeline datapath and its central sequencing unit.
//
// Signals (datapath -> controller):
//   ihit, dhit             memory port completion for fetch / data access
//   mem_dREN, mem_dWEN     MEM-stage load / store
//   mem_pcsrc, mem_halt    MEM-stage redirect / halt
//   ex_dREN, ex_wsel       EX-stage load and its destination register
//   id_rs, id_rt,
//   id_uses_rt             ID-stage source registers
// Signals (controller -> datapath):
//   pc_en                  PC update enable
//   xl_en, xl_flush        enable/flush for fetch, decode, execute, memory latches
//   halt                   sticky halted indication
//   stall_cnt, flush_cnt   saturating performance counters
//
// Modports: master = datapath side, slave = controller side.
// ----------------------------------------------------------------------------
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic             mem_dREN;
    logic             mem_dWEN;
    logic             mem_pcsrc;
    logic             mem_halt;
    logic             ex_dREN;
    logic [4:0]       ex_wsel;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;

    logic             pc_en;
    logic             fl_en;
    logic             fl_flush;
    logic             dl_en;
    logic             dl_flush;
    logic             el_en;
    logic             el_flush;
    logic             ml_en;
    logic             ml_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ihit, dhit, mem_dREN, mem_dWEN, mem_pcsrc, mem_halt,
               ex_dREN, ex_wsel, id_rs, id_rt, id_uses_rt,
        input  pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush,
               ml_en, ml_flush, halt, stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, mem_dREN, mem_dWEN, mem_pcsrc, mem_halt,
               ex_dREN, ex_wsel, id_rs, id_rt, id_uses_rt,
        output pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush,
               ml_en, ml_flush, halt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
// Central sequencing unit for the five-stage pipeline. Produces enable/flush
// for the fetch, decode, execute and memory latches plus the PC enable,
// arbitrates the shared memory port between fetch and data access, inserts
// load-use bubbles, squashes wrong-path work on redirect and drains the pipe
// on halt. Keeps saturating stall and redirect counters.
//
// Ports:
//   CLK      system clock
//   RST      asynchronous reset, active-high; forces every output to 0
//   ctrlBus  pipeline_ctrl_if.slave (hazard inputs, latch-control outputs)
// ----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic            CLK,
    input  logic            RST,
    pipeline_ctrl_if.slave  ctrlBus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    logic w_memop;
    logic w_loadUse;
    logic w_stallInc;
    logic w_flushInc;

    logic w_pcEn;
    logic w_flEn;
    logic w_flFlush;
    logic w_dlEn;
    logic w_dlFlush;
    logic w_elEn;
    logic w_elFlush;
    logic w_mlEn;
    logic w_mlFlush;
    logic w_halt;

    assign w_memop   = ctrlBus.mem_dREN | ctrlBus.mem_dWEN;

    // A load in EX feeding a source of the ID instruction needs one bubble;
    // x0 is hardwired so it never creates a dependency.
    assign w_loadUse = ctrlBus.ex_dREN && (ctrlBus.ex_wsel != 5'd0) &&
                       ((ctrlBus.ex_wsel == ctrlBus.id_rs) ||
                        (ctrlBus.id_uses_rt && (ctrlBus.ex_wsel == ctrlBus.id_rt)));

    // Latch controls, next state and counter increments, decoded from the
    // current state and this cycle's hazards. Default is a full freeze.
    always_comb begin
        w_nextState = r_state;
        w_stallInc  = 1'b0;
        w_flushInc  = 1'b0;
        w_pcEn      = 1'b0;
        w_flEn      = 1'b0;
        w_flFlush   = 1'b0;
        w_dlEn      = 1'b0;
        w_dlFlush   = 1'b0;
        w_elEn      = 1'b0;
        w_elFlush   = 1'b0;
        w_mlEn      = 1'b0;
        w_mlFlush   = 1'b0;
        w_halt      = 1'b0;

        case (r_state)
            RUN: begin
                if (ctrlBus.mem_halt) begin
                    // Let halt retire from MEM, squash everything behind it.
                    w_mlEn      = 1'b1;
                    w_flFlush   = 1'b1;
                    w_dlFlush   = 1'b1;
                    w_elFlush   = 1'b1;
                    w_nextState = HALTED;
                end else if (w_memop && !ctrlBus.dhit) begin
                    w_stallInc  = 1'b1;
                    w_nextState = DWAIT;
                end else if (w_memop) begin
                    // Data owned the memory port, so fetch gets a bubble.
                    w_dlEn    = 1'b1;
                    w_elEn    = 1'b1;
                    w_mlEn    = 1'b1;
                    w_flFlush = 1'b1;
                    if (ctrlBus.mem_pcsrc) begin
                        w_pcEn     = 1'b1;
                        w_dlEn     = 1'b0;
                        w_dlFlush  = 1'b1;
                        w_elEn     = 1'b0;
                        w_elFlush  = 1'b1;
                        w_flushInc = 1'b1;
                    end
                end else if (ctrlBus.mem_pcsrc) begin
                    w_pcEn     = 1'b1;
                    w_flFlush  = 1'b1;
                    w_dlFlush  = 1'b1;
                    w_elFlush  = 1'b1;
                    w_mlEn     = 1'b1;
                    w_flushInc = 1'b1;
                end else if (w_loadUse) begin
                    // Hold fetch/decode, push a bubble into execute.
                    w_dlFlush  = 1'b1;
                    w_elEn     = 1'b1;
                    w_mlEn     = 1'b1;
                    w_stallInc = 1'b1;
                end else if (!ctrlBus.ihit) begin
                    w_flFlush  = 1'b1;
                    w_dlEn     = 1'b1;
                    w_elEn     = 1'b1;
                    w_mlEn     = 1'b1;
                    w_stallInc = 1'b1;
                end else begin
                    w_pcEn = 1'b1;
                    w_flEn = 1'b1;
                    w_dlEn = 1'b1;
                    w_elEn = 1'b1;
                    w_mlEn = 1'b1;
                end
            end

            DWAIT: begin
                // Fetch status is irrelevant here: data still holds the port.
                if (!ctrlBus.dhit) begin
                    w_stallInc = 1'b1;
                end else begin
                    w_dlEn      = 1'b1;
                    w_elEn      = 1'b1;
                    w_mlEn      = 1'b1;
                    w_flFlush   = 1'b1;
                    w_nextState = RUN;
                    if (ctrlBus.mem_pcsrc) begin
                        w_pcEn     = 1'b1;
                        w_dlEn     = 1'b0;
                        w_dlFlush  = 1'b1;
                        w_elEn     = 1'b0;
                        w_elFlush  = 1'b1;
                        w_flushInc = 1'b1;
                    end
                end
            end

            HALTED: begin
                w_halt = 1'b1;
            end

            default: begin
                w_nextState = RUN;
            end
        endcase
    end

    // State and saturating counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= RUN;
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_stallInc && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
            if (w_flushInc && (r_flushCnt != '1)) begin
                r_flushCnt <= r_flushCnt + 1'b1;
            end
        end
    end

    // Reset masks every output immediately, even mid-operation.
    assign ctrlBus.pc_en     = w_pcEn    & ~RST;
    assign ctrlBus.fl_en     = w_flEn    & ~RST;
    assign ctrlBus.fl_flush  = w_flFlush & ~RST;
    assign ctrlBus.dl_en     = w_dlEn    & ~RST;
    assign ctrlBus.dl_flush  = w_dlFlush & ~RST;
    assign ctrlBus.el_en     = w_elEn    & ~RST;
    assign ctrlBus.el_flush  = w_elFlush & ~RST;
    assign ctrlBus.ml_en     = w_mlEn    & ~RST;
    assign ctrlBus.ml_flush  = w_mlFlush & ~RST;
    assign ctrlBus.halt      = w_halt    & ~RST;
    assign ctrlBus.stall_cnt = RST ? '0 : r_stallCnt;
    assign ctrlBus.flush_cnt = RST ? '0 : r_flushCnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Table-driven bench for pipeline_ctrl. Each record carries the hazard inputs
// for one cycle plus the latch controls, halt flag and counter values that
// must be visible during that cycle. Expectations are queued when a record is
// driven and popped when the outputs are sampled mid-cycle. A second
// instance with 2-bit counters covers counter saturation.
// ----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    // Packed control order: {pc_en, fl_en, fl_flush, dl_en, dl_flush,
    //                        el_en, el_flush, ml_en, ml_flush}
    localparam logic [8:0] C_RUN    = 9'b1_10_10_10_10;
    localparam logic [8:0] C_FREEZE = 9'b0_00_00_00_00;
    localparam logic [8:0] C_LU     = 9'b0_00_01_10_10;
    localparam logic [8:0] C_NOIHIT = 9'b0_01_10_10_10;
    localparam logic [8:0] C_DHIT   = 9'b0_01_10_10_10;
    localparam logic [8:0] C_REDIR  = 9'b1_01_01_01_10;
    localparam logic [8:0] C_HALTNG = 9'b0_01_01_01_10;

    typedef struct {
        logic        ihit;
        logic        dhit;
        logic        dREN;
        logic        dWEN;
        logic        pcsrc;
        logic        mhalt;
        logic        exDREN;
        logic [4:0]  exWsel;
        logic [4:0]  idRs;
        logic [4:0]  idRt;
        logic        usesRt;
        logic [8:0]  expCtrl;
        logic        expHalt;
        logic [15:0] expStall;
        logic [15:0] expFlush;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t sbQ[$];
    vec_t vecs[$];

    pipeline_ctrl_if #(.CNT_W(16)) ifMain ();
    pipeline_ctrl_if #(.CNT_W(2))  ifSat ();

    pipeline_ctrl #(.CNT_W(16)) dut (
        .CLK     (clk),
        .RST     (rst),
        .ctrlBus (ifMain)
    );

    pipeline_ctrl #(.CNT_W(2)) dutSat (
        .CLK     (clk),
        .RST     (rst),
        .ctrlBus (ifSat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic ih, logic dh, logic rd, logic wr, logic pc,
                                logic mh, logic exr, logic [4:0] ws, logic [4:0] rs,
                                logic [4:0] rt, logic ur, logic [8:0] c, logic h,
                                int s, int f);
        vec_t v;
        v.ihit = ih;  v.dhit = dh;  v.dREN = rd;  v.dWEN = wr;
        v.pcsrc = pc; v.mhalt = mh; v.exDREN = exr;
        v.exWsel = ws; v.idRs = rs; v.idRt = rt; v.usesRt = ur;
        v.expCtrl = c; v.expHalt = h;
        v.expStall = 16'(s); v.expFlush = 16'(f);
        return v;
    endfunction

    function automatic vec_t randZero();
        vec_t v;
        v = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
               5'($urandom), 5'($urandom), 1'($urandom), C_FREEZE, 1'b0, 0, 0);
        return v;
    endfunction

    task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        ifMain.ihit       = v.ihit;
        ifMain.dhit       = v.dhit;
        ifMain.mem_dREN   = v.dREN;
        ifMain.mem_dWEN   = v.dWEN;
        ifMain.mem_pcsrc  = v.pcsrc;
        ifMain.mem_halt   = v.mhalt;
        ifMain.ex_dREN    = v.exDREN;
        ifMain.ex_wsel    = v.exWsel;
        ifMain.id_rs      = v.idRs;
        ifMain.id_rt      = v.idRt;
        ifMain.id_uses_rt = v.usesRt;
        sbQ.push_back(v);
    endtask

    task automatic checkOutput(input string tag);
        vec_t       v;
        logic [8:0] ctrl;
        if (sbQ.size() == 0) begin
            compare({tag, "_sbempty"}, 16'd0, 16'd1);
            return;
        end
        v = sbQ.pop_front();
        ctrl = {ifMain.pc_en, ifMain.fl_en, ifMain.fl_flush, ifMain.dl_en,
                ifMain.dl_flush, ifMain.el_en, ifMain.el_flush, ifMain.ml_en,
                ifMain.ml_flush};
        compare({tag, "_ctrl"},  {7'd0, ctrl},          {7'd0, v.expCtrl});
        compare({tag, "_halt"},  {15'd0, ifMain.halt},  {15'd0, v.expHalt});
        compare({tag, "_stall"}, ifMain.stall_cnt,      v.expStall);
        compare({tag, "_flush"}, ifMain.flush_cnt,      v.expFlush);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;

        ifSat.ihit = 1'b1; ifSat.dhit = 1'b0; ifSat.mem_dREN = 1'b0;
        ifSat.mem_dWEN = 1'b0; ifSat.mem_pcsrc = 1'b0; ifSat.mem_halt = 1'b0;
        ifSat.ex_dREN = 1'b0; ifSat.ex_wsel = 5'd0; ifSat.id_rs = 5'd0;
        ifSat.id_rt = 5'd0; ifSat.id_uses_rt = 1'b0;

        // Cycle-by-cycle program starting right after reset release.
        //               ih dh rd wr pc mh exr ws  rs  rt ur  ctrl     h  stall flush
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, C_RUN,    0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  5,  5,  0, 0, C_LU,     0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  7,  3,  7, 1, C_LU,     0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  7,  3,  7, 0, C_RUN,    0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  0,  0,  0, 1, C_RUN,    0, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  5,  0,  5, 1, C_LU,     0, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, C_NOIHIT, 0, 3, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,  0,  0,  0, 0, C_FREEZE, 0, 4, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,  0,  0,  0, 0, C_FREEZE, 0, 5, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,  0,  0,  0, 0, C_FREEZE, 0, 6, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0,  0,  0,  0, 0, C_DHIT,   0, 7, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, C_RUN,    0, 7, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0,  0,  0,  0, 0, C_DHIT,   0, 7, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0,  0,  0,  0, 0, C_REDIR,  0, 7, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1,  5,  5,  0, 0, C_REDIR,  0, 7, 1));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0,  0,  0,  0, 0, C_REDIR,  0, 7, 2));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0,  0,  0,  0, 0, C_FREEZE, 0, 7, 3));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 0,  0,  0,  0, 0, C_REDIR,  0, 8, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, C_RUN,    0, 8, 4));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 1,  5,  5,  0, 0, C_HALTNG, 0, 8, 4));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0,  0,  0,  0, 0, C_FREEZE, 1, 8, 4));
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 1,  9,  9,  0, 0, C_FREEZE, 1, 8, 4));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  0,  0,  0, 0, C_FREEZE, 1, 8, 4));

        // Outputs held at zero while reset is asserted, whatever the inputs.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(randZero());
            #2;
            checkOutput("reset_hold");
        end

        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i));
            @(posedge clk); #1;
        end

        // Reset pulse out of HALTED returns to RUN with cleared counters.
        rst = 1'b1;
        applyStimulus(randZero());
        #1;
        checkOutput("halted_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0));
        @(negedge clk);
        checkOutput("after_reset_run");
        @(posedge clk); #1;

        // Reset asserted mid-operation masks outputs immediately.
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 1, 4, 4, 0, 0, C_LU, 0, 0, 0));
        @(negedge clk);
        checkOutput("pre_midreset_lu");
        @(posedge clk); #1;
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 1, 0));
        #1;
        checkOutput("pre_midreset_run");
        rst = 1'b1;
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_FREEZE, 0, 0, 0));
        #1;
        checkOutput("midreset");

        // Saturation on the 2-bit instance: five fetch misses in a row.
        @(posedge clk); #1;
        rst = 1'b0;
        ifSat.ihit = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            compare($sformatf("sat_stall%0d", k), {14'd0, ifSat.stall_cnt},
                    (k < 3) ? 16'(k) : 16'd3);
            @(posedge clk); #1;
        end
        @(negedge clk);
        compare("sat_stall_final", {14'd0, ifSat.stall_cnt}, 16'd3);
        compare("sat_flush", {14'd0, ifSat.flush_cnt}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #20000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
